seu_err_collector: RTL



---
 rtl/seu_err_collector.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seu_err_collector.sv
// Error collector for the SET detector array: per-source saturating counters,
// sticky status, first-error capture, threshold interrupt and a 4-phase clear handshake.
module seu_err_collector #(
    parameter int N_SRC     = 4,
    parameter int CNT_W     = 8,
    parameter int INTR_TH   = 1,
    parameter int BLANK_CYC = 2,
    parameter int IDX_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_SRC-1:0]         err_i,
    input  logic [N_SRC-1:0]         mask_i,
    input  logic                     clr_req_i,
    input  logic [N_SRC-1:0]         clr_src_i,
    output logic                     clr_ack_o,
    output logic [N_SRC-1:0]         status_o,
    output logic [N_SRC*CNT_W-1:0]   cnt_o,
    output logic                     first_vld_o,
    output logic [IDX_W-1:0]         first_idx_o,
    output logic                     irq_o
);

    localparam int                BW         = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0]     BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  CNT_TH     = CNT_W'(INTR_TH);

    typedef enum logic [1:0] {ST_BLANK, ST_RUN, ST_CLR, ST_ACK} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_SRC-1:0] v);
        lowest_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    state_t             r_state, w_state_nxt;
    logic [BW-1:0]      r_blank_cnt, w_blank_nxt;
    logic [CNT_W-1:0]   r_cnt [N_SRC];
    logic [CNT_W-1:0]   w_cnt_nxt [N_SRC];
    logic [N_SRC-1:0]   r_status, w_status_nxt;
    logic               r_first_vld, w_first_vld_nxt;
    logic [IDX_W-1:0]   r_first_idx, w_first_idx_nxt;
    logic               r_irq, w_irq_nxt;
    logic [N_SRC-1:0]   w_ev;
    logic               w_clr_fire;
    logic               w_rearm;
    logic               w_vld_base;

    always_comb begin
        w_state_nxt = r_state;
        w_blank_nxt = r_blank_cnt;
        case (r_state)
            ST_BLANK: begin
                if (r_blank_cnt == BLANK_LAST) w_state_nxt = ST_RUN;
                else                           w_blank_nxt = r_blank_cnt + 1'b1;
            end
            ST_RUN:  if (clr_req_i)  w_state_nxt = ST_CLR;
            ST_CLR:                  w_state_nxt = ST_ACK;
            ST_ACK:  if (!clr_req_i) w_state_nxt = ST_RUN;
            default:                 w_state_nxt = ST_BLANK;
        endcase
    end

    // Detector outputs are unreset, so nothing is trusted until blanking ends.
    assign w_ev       = (r_state != ST_BLANK) ? (err_i & ~mask_i) : '0;
    assign w_clr_fire = (r_state == ST_RUN) && clr_req_i;

    always_comb begin
        w_status_nxt = r_status;
        w_irq_nxt    = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_clr_fire && clr_src_i[i]) begin
                w_cnt_nxt[i]    = CNT_W'(w_ev[i]);
                w_status_nxt[i] = w_ev[i];
            end else if (w_ev[i]) begin
                w_cnt_nxt[i]    = sat_inc(r_cnt[i]);
                w_status_nxt[i] = 1'b1;
            end
            if ((w_cnt_nxt[i] >= CNT_TH) && !mask_i[i]) w_irq_nxt = 1'b1;
        end
    end

    // Clearing the captured source re-arms capture; an event on the same edge recaptures.
    assign w_rearm    = w_clr_fire && r_first_vld && clr_src_i[r_first_idx];
    assign w_vld_base = r_first_vld && !w_rearm;

    always_comb begin
        w_first_vld_nxt = w_vld_base;
        w_first_idx_nxt = r_first_idx;
        if (!w_vld_base && (w_ev != '0)) begin
            w_first_vld_nxt = 1'b1;
            w_first_idx_nxt = lowest_idx(w_ev);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_BLANK;
            r_blank_cnt <= '0;
            r_status    <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
            r_irq       <= 1'b0;
            for (int i = 0; i < N_SRC; i++) r_cnt[i] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_blank_cnt <= w_blank_nxt;
            r_status    <= w_status_nxt;
            r_first_vld <= w_first_vld_nxt;
            r_first_idx <= w_first_idx_nxt;
            r_irq       <= w_irq_nxt;
            for (int i = 0; i < N_SRC; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) cnt_o[i*CNT_W +: CNT_W] = r_cnt[i];
    end

    assign clr_ack_o   = (r_state == ST_CLR) || (r_state == ST_ACK);
    assign status_o    = r_status;
    assign first_vld_o = r_first_vld;
    assign first_idx_o = r_first_idx;
    assign irq_o       = r_irq;

endmodule
